mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port, variable-latency memory between the core's instruction-fetch port and data port. Sits between the pipelined RISC core and a unified RAM, with one transaction outstanding at a time. Data accesses have priority. A streak counter guarantees instruction fetch cannot be starved. Every response is routed back to the requester that issued it, as a one-cycle valid pulse.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_STREAK, 4, max consecutive data grants while an instruction fetch waits (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  instruction fetch request, held until i_data_valid
- i_address  in  AW  fetch address, stable while i_req
- i_data_read  out  DW  fetched word, valid when i_data_valid
- i_data_valid  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request, held until d_data_valid
- d_address  in  AW  data address
- d_data_write  in  DW  store data
- d_write_enable  in  1  1 = store, 0 = load
- d_data_read  out  DW  load data, valid when d_data_valid
- d_data_valid  out  1  one-cycle completion pulse for load or store
- m_req  out  1  memory request, held until m_ack
- m_address  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_we  out  1  memory write enable
- m_rdata  in  DW  memory read data, sampled with m_ack
- m_ack  in  1  memory completion, single cycle

## Operation
- States:
  - ARB_IDLE → ARB_GRANT_I when the fetch port wins arbitration.
  - ARB_IDLE → ARB_GRANT_D when the data port wins arbitration.
  - ARB_GRANT_I / ARB_GRANT_D → ARB_IDLE on m_ack.
- Arbitration happens only in ARB_IDLE:
  - Grant D if d_req && !(i_req && streak == MAX_STREAK).
  - Otherwise grant I if i_req.
  - Otherwise stay in ARB_IDLE.
- At grant, register the winner's address, write data and write enable into m_address / m_wdata / m_we.
  - For an I grant: m_we = 0 and m_wdata = 0.
  - These registers hold until the next grant.
- m_req = 1 exactly while in a GRANT state.
- On m_ack in ARB_GRANT_I:
  - Register m_rdata into i_data_read.
  - Pulse i_data_valid in the following cycle.
- On m_ack in ARB_GRANT_D:
  - Pulse d_data_valid in the following cycle.
  - Update d_data_read from m_rdata only when m_we = 0; for stores it keeps its previous value.
- Completion-cycle masking: in the cycle a requester's valid is high, that requester's req is ignored for arbitration, since it may still be asserted. The other requester may be granted in that cycle.
- Streak counter, width $clog2(MAX_STREAK+1):
  - On a D grant with i_req = 1: increment, saturating at MAX_STREAK.
  - On a D grant with i_req = 0: clear.
  - On an I grant: clear.
- m_ack while in ARB_IDLE is ignored.
- Reset (asynchronous, may arrive mid-transaction):
  - State returns to ARB_IDLE; streak = 0.
  - m_req, m_we, both valids = 0; all address and data registers = 0.
  - Any in-flight memory access is abandoned.
  - The first post-reset m_ack is ignored, because the block is in ARB_IDLE.

## Timing
- Request seen in ARB_IDLE at cycle t → m_req high at t+1.
- Zero-wait memory acks at t+1 → valid pulse at t+2.
- Each memory wait cycle adds one cycle of latency.
- Maximum throughput is one access per 2 cycles. A new grant may be made in the same cycle as the previous valid pulse.
- Outputs are registered: no combinational path from any input to any output.
- Worst-case fetch wait under continuous d_req is MAX_STREAK data transactions.

## Structure
- Shared package (the core's existing package): state typedef arb_state_t {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}.
- Single module; no sub-module. Streak counter and FSM are inline.

## Test plan
- Lone fetch: i_req, i_address=0x100, ack same cycle as m_req, m_rdata=0x00500093 → m_address=0x100 at t+1, i_data_valid=1 with 0x00500093 at t+2, exactly one pulse.
- Simultaneous requests: i_req at 0x104, d_req load at 0x2000, memory returns 0xDEADBEEF for the load → data served first with d_data_read=0xDEADBEEF, then fetch granted in the d_data_valid cycle.
- Store then load:
  - Store 0x12345678 to 0x40 → m_we=1, m_wdata=0x12345678, d_data_valid pulse, d_data_read unchanged.
  - Load from 0x40 → d_data_read=0x12345678.
- Starvation guard: d_req held continuously with i_req high, MAX_STREAK=4 → exactly 4 D grants, then an I grant, then the streak restarts at 0.
- Wait states: m_ack delayed 3 cycles → m_req and m_address stable for 4 cycles, valid exactly one cycle after the ack.
- Reset mid-transaction: assert reset while in ARB_GRANT_D, then send m_ack after release → all outputs 0 immediately, no valid pulse, state ARB_IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM encoding (idle, fetch granted, data granted)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port, variable-latency memory between the core's
// instruction-fetch port (i_*) and data port (d_*). One transaction is
// outstanding at a time. Data accesses win arbitration unless a fetch has been
// waiting through MAX_STREAK consecutive data grants. Each response returns to
// its requester as a one-cycle valid pulse. All outputs come straight from
// flops.
//
// Ports
//   clk, reset                : clock, asynchronous active-high reset
//   i_req / i_address         : fetch request, held until i_data_valid
//   i_data_read/i_data_valid  : fetched word and completion pulse
//   d_req / d_address         : data request, held until d_data_valid
//   d_data_write/d_write_enable : store data, 1 = store / 0 = load
//   d_data_read/d_data_valid  : load data and completion pulse
//   m_req/m_address/m_wdata/m_we : memory request, held until m_ack
//   m_rdata/m_ack             : memory read data and single-cycle completion
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_address,
    output logic [DW-1:0] i_data_read,
    output logic          i_data_valid,
    input  logic          d_req,
    input  logic [AW-1:0] d_address,
    input  logic [DW-1:0] d_data_write,
    input  logic          d_write_enable,
    output logic [DW-1:0] d_data_read,
    output logic          d_data_valid,
    output logic          m_req,
    output logic [AW-1:0] m_address,
    output logic [DW-1:0] m_wdata,
    output logic          m_we,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          m_req_q, m_req_d;
    logic [AW-1:0] m_address_q, m_address_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic          m_we_q, m_we_d;
    logic [DW-1:0] i_data_read_q, i_data_read_d;
    logic          i_data_valid_q, i_data_valid_d;
    logic [DW-1:0] d_data_read_q, d_data_read_d;
    logic          d_data_valid_q, d_data_valid_d;

    // A requester's req is still high in its own valid cycle; mask it there so
    // the finished access is not granted a second time.
    logic i_eff_s;
    logic d_eff_s;
    logic grant_d_s;
    logic grant_i_s;

    // Arbitration decision: data first, unless the waiting fetch hit the streak cap.
    always_comb begin
        i_eff_s   = i_req && !i_data_valid_q;
        d_eff_s   = d_req && !d_data_valid_q;
        grant_d_s = d_eff_s && !(i_eff_s && (streak_q == STREAK_MAX));
        grant_i_s = !grant_d_s && i_eff_s;
    end

    // Next-state logic for the FSM, memory request registers, streak and responses.
    always_comb begin
        state_d        = state_q;
        streak_d       = streak_q;
        m_req_d        = m_req_q;
        m_address_d    = m_address_q;
        m_wdata_d      = m_wdata_q;
        m_we_d         = m_we_q;
        i_data_read_d  = i_data_read_q;
        i_data_valid_d = 1'b0;
        d_data_read_d  = d_data_read_q;
        d_data_valid_d = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // m_ack arriving here (e.g. from an access abandoned by reset) is ignored.
                if (grant_d_s) begin
                    state_d     = ARB_GRANT_D;
                    m_req_d     = 1'b1;
                    m_address_d = d_address;
                    m_wdata_d   = d_data_write;
                    m_we_d      = d_write_enable;
                    if (i_req) begin
                        if (streak_q == STREAK_MAX) begin
                            streak_d = streak_q;
                        end else begin
                            streak_d = streak_q + SW'(1);
                        end
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_i_s) begin
                    state_d     = ARB_GRANT_I;
                    m_req_d     = 1'b1;
                    m_address_d = i_address;
                    m_wdata_d   = '0;
                    m_we_d      = 1'b0;
                    streak_d    = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT_I: begin
                if (m_ack) begin
                    state_d        = ARB_IDLE;
                    m_req_d        = 1'b0;
                    i_data_read_d  = m_rdata;
                    i_data_valid_d = 1'b1;
                end else begin
                    state_d = ARB_GRANT_I;
                end
            end
            ARB_GRANT_D: begin
                if (m_ack) begin
                    state_d        = ARB_IDLE;
                    m_req_d        = 1'b0;
                    d_data_valid_d = 1'b1;
                    // Stores return no data; keep the last load result visible.
                    if (!m_we_q) begin
                        d_data_read_d = m_rdata;
                    end else begin
                        d_data_read_d = d_data_read_q;
                    end
                end else begin
                    state_d = ARB_GRANT_D;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ARB_IDLE;
            streak_q       <= '0;
            m_req_q        <= 1'b0;
            m_address_q    <= '0;
            m_wdata_q      <= '0;
            m_we_q         <= 1'b0;
            i_data_read_q  <= '0;
            i_data_valid_q <= 1'b0;
            d_data_read_q  <= '0;
            d_data_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            streak_q       <= streak_d;
            m_req_q        <= m_req_d;
            m_address_q    <= m_address_d;
            m_wdata_q      <= m_wdata_d;
            m_we_q         <= m_we_d;
            i_data_read_q  <= i_data_read_d;
            i_data_valid_q <= i_data_valid_d;
            d_data_read_q  <= d_data_read_d;
            d_data_valid_q <= d_data_valid_d;
        end
    end

    assign m_req        = m_req_q;
    assign m_address    = m_address_q;
    assign m_wdata      = m_wdata_q;
    assign m_we         = m_we_q;
    assign i_data_read  = i_data_read_q;
    assign i_data_valid = i_data_valid_q;
    assign d_data_read  = d_data_read_q;
    assign d_data_valid = d_data_valid_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed test of mem_arbiter with hand-computed expected values. Inputs are
// driven and outputs sampled 1 ns after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_address;
    logic [31:0] i_data_read;
    logic        i_data_valid;
    logic        d_req;
    logic [31:0] d_address;
    logic [31:0] d_data_write;
    logic        d_write_enable;
    logic [31:0] d_data_read;
    logic        d_data_valid;
    logic        m_req;
    logic [31:0] m_address;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [31:0] m_rdata;
    logic        m_ack;

    int vec_cnt;
    int err_cnt;

    mem_arbiter #(
        .AW         (32),
        .DW         (32),
        .MAX_STREAK (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (i_req),
        .i_address      (i_address),
        .i_data_read    (i_data_read),
        .i_data_valid   (i_data_valid),
        .d_req          (d_req),
        .d_address      (d_address),
        .d_data_write   (d_data_write),
        .d_write_enable (d_write_enable),
        .d_data_read    (d_data_read),
        .d_data_valid   (d_data_valid),
        .m_req          (m_req),
        .m_address      (m_address),
        .m_wdata        (m_wdata),
        .m_we           (m_we),
        .m_rdata        (m_rdata),
        .m_ack          (m_ack)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_cnt        = 0;
        err_cnt        = 0;
        reset          = 1'b1;
        i_req          = 1'b0;
        i_address      = 32'h0;
        d_req          = 1'b0;
        d_address      = 32'h0;
        d_data_write   = 32'h0;
        d_write_enable = 1'b0;
        m_rdata        = 32'h0;
        m_ack          = 1'b0;
        tick();
        tick();
        check_eq("rst_m_req", {31'd0, m_req}, 32'd0);
        check_eq("rst_m_address", m_address, 32'h0);
        check_eq("rst_i_valid", {31'd0, i_data_valid}, 32'd0);
        check_eq("rst_d_valid", {31'd0, d_data_valid}, 32'd0);
        reset = 1'b0;
        tick();

        // ---- Lone fetch, zero-wait memory ----
        i_req = 1'b1; i_address = 32'h100;
        tick();
        check_eq("fetch_m_req", {31'd0, m_req}, 32'd1);
        check_eq("fetch_m_address", m_address, 32'h100);
        check_eq("fetch_m_we", {31'd0, m_we}, 32'd0);
        m_ack = 1'b1; m_rdata = 32'h00500093;
        tick();
        check_eq("fetch_i_valid", {31'd0, i_data_valid}, 32'd1);
        check_eq("fetch_i_data", i_data_read, 32'h00500093);
        check_eq("fetch_m_req_drop", {31'd0, m_req}, 32'd0);
        // i_req still high in the valid cycle: must not be regranted.
        m_ack = 1'b0;
        tick();
        i_req = 1'b0;
        check_eq("fetch_single_pulse", {31'd0, i_data_valid}, 32'd0);
        check_eq("fetch_no_regrant", {31'd0, m_req}, 32'd0);
        tick();

        // ---- Simultaneous requests: data first, then fetch in d_valid cycle ----
        i_req = 1'b1; i_address = 32'h104;
        d_req = 1'b1; d_address = 32'h2000; d_write_enable = 1'b0; d_data_write = 32'h0;
        tick();
        check_eq("sim_d_first_addr", m_address, 32'h2000);
        m_ack = 1'b1; m_rdata = 32'hDEADBEEF;
        tick();
        check_eq("sim_d_valid", {31'd0, d_data_valid}, 32'd1);
        check_eq("sim_d_data", d_data_read, 32'hDEADBEEF);
        check_eq("sim_i_not_yet", {31'd0, i_data_valid}, 32'd0);
        m_ack = 1'b0;
        tick();
        d_req = 1'b0;
        check_eq("sim_i_granted", {31'd0, m_req}, 32'd1);
        check_eq("sim_i_addr", m_address, 32'h104);
        check_eq("sim_d_pulse_end", {31'd0, d_data_valid}, 32'd0);
        m_ack = 1'b1; m_rdata = 32'h00000013;
        tick();
        check_eq("sim_i_valid", {31'd0, i_data_valid}, 32'd1);
        check_eq("sim_i_data", i_data_read, 32'h00000013);
        m_ack = 1'b0;
        tick();
        i_req = 1'b0;
        tick();

        // ---- Store then load ----
        d_req = 1'b1; d_address = 32'h40; d_data_write = 32'h12345678; d_write_enable = 1'b1;
        tick();
        check_eq("st_m_we", {31'd0, m_we}, 32'd1);
        check_eq("st_m_wdata", m_wdata, 32'h12345678);
        check_eq("st_m_addr", m_address, 32'h40);
        m_ack = 1'b1; m_rdata = 32'hCAFEF00D;
        tick();
        check_eq("st_d_valid", {31'd0, d_data_valid}, 32'd1);
        check_eq("st_d_data_kept", d_data_read, 32'hDEADBEEF);
        m_ack = 1'b0;
        tick();
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_write_enable = 1'b0;
        tick();
        check_eq("ld_m_we", {31'd0, m_we}, 32'd0);
        m_ack = 1'b1; m_rdata = 32'h12345678;
        tick();
        check_eq("ld_d_data", d_data_read, 32'h12345678);
        m_ack = 1'b0;
        tick();
        d_req = 1'b0;
        tick();

        // ---- Wait states: fetch with ack three cycles late ----
        i_req = 1'b1; i_address = 32'h300;
        tick();
        check_eq("ws_i_m_wdata_zero", m_wdata, 32'h0);
        for (int w = 0; w < 3; w++) begin
            check_eq("ws_m_req_hold", {31'd0, m_req}, 32'd1);
            check_eq("ws_m_addr_hold", m_address, 32'h300);
            check_eq("ws_no_valid", {31'd0, i_data_valid}, 32'd0);
            tick();
        end
        check_eq("ws_m_req_4th", {31'd0, m_req}, 32'd1);
        m_ack = 1'b1; m_rdata = 32'h0000A5A5;
        tick();
        check_eq("ws_i_valid", {31'd0, i_data_valid}, 32'd1);
        check_eq("ws_i_data", i_data_read, 32'h0000A5A5);
        m_ack = 1'b0;
        tick();
        i_req = 1'b0;
        check_eq("ws_valid_one_cycle", {31'd0, i_data_valid}, 32'd0);
        tick();

        // ---- Starvation guard: four D grants while a fetch waits, then I wins ----
        for (int k = 0; k < 4; k++) begin
            i_req = 1'b1; i_address = 32'h500;
            d_req = 1'b1; d_address = 32'h600 + 32'(k); d_write_enable = 1'b0;
            tick();
            check_eq("stv_d_grant", m_address, 32'h600 + 32'(k));
            i_req = 1'b0;   // fetch withdraws so it does not win in the d_valid cycle
            m_ack = 1'b1; m_rdata = 32'h0;
            tick();
            m_ack = 1'b0; d_req = 1'b0;
            tick();
        end
        i_req = 1'b1; d_req = 1'b1; d_address = 32'h700;
        tick();
        check_eq("stv_i_after_cap", m_address, 32'h500);
        check_eq("stv_i_we", {31'd0, m_we}, 32'd0);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0; i_req = 1'b0;
        check_eq("stv_i_valid", {31'd0, i_data_valid}, 32'd1);
        // d_req still pending: granted here since the fetch valid cycle only masks i_req.
        tick();
        check_eq("stv_d_after_i", m_address, 32'h700);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0; d_req = 1'b0;
        tick();
        // Streak restarted: with both requesting, data wins again.
        i_req = 1'b1; d_req = 1'b1; d_address = 32'h800;
        tick();
        check_eq("stv_restart_d", m_address, 32'h800);
        i_req = 1'b0;
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0; d_req = 1'b0;
        tick();

        // ---- Reset in the middle of a data transaction ----
        d_req = 1'b1; d_address = 32'h80; d_data_write = 32'hAA; d_write_enable = 1'b1;
        tick();
        check_eq("rmid_granted", {31'd0, m_req}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rmid_m_req", {31'd0, m_req}, 32'd0);
        check_eq("rmid_m_addr", m_address, 32'h0);
        check_eq("rmid_m_wdata", m_wdata, 32'h0);
        check_eq("rmid_m_we", {31'd0, m_we}, 32'd0);
        check_eq("rmid_d_data", d_data_read, 32'h0);
        check_eq("rmid_i_data", i_data_read, 32'h0);
        d_req = 1'b0;
        tick();
        reset = 1'b0;
        m_ack = 1'b1; m_rdata = 32'h55555555;
        tick();
        check_eq("rmid_ack_ignored_d", {31'd0, d_data_valid}, 32'd0);
        check_eq("rmid_ack_ignored_i", {31'd0, i_data_valid}, 32'd0);
        check_eq("rmid_idle", {31'd0, m_req}, 32'd0);
        m_ack = 1'b0;
        tick();
        check_eq("rmid_no_late_valid", {31'd0, d_data_valid}, 32'd0);
        check_eq("rmid_d_data_zero", d_data_read, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_mem_arbiter
